// File: rtl/fma_sched.sv
// Round-robin issue scheduler for one shared fma pipeline, with a credit-guarded in-order result FIFO.
// Define FMA_SCHED_PERF_EN to add the perf_issue / perf_stall counters.
module fma_sched #(
    parameter  int NREQ  = 4,
    parameter  int LAT   = 4,
    parameter  int DEPTH = 8,
    parameter  int RES_W = 300,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [6*NREQ-1:0]    req_cfg,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      fma_sel,
    output logic [5:0]           fma_cfg,
    output logic                 issue_valid,
    input  logic [RES_W-1:0]     res_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [RES_W-1:0]     resp_data,
    output logic [CW-1:0]        credits,
    output logic                 idle
`ifdef FMA_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issue,
    output logic [31:0]          perf_stall
`endif
);

    logic [IDW-1:0]       last_q, last_d;
    logic [CW-1:0]        credits_q, credits_d;
    logic [PW:0]          wr_q, wr_d, rd_q, rd_d;
    logic [LAT-1:0]       tag_vld_q, tag_vld_d;
    logic [IDW-1:0]       tag_id_q [LAT];
    logic [IDW-1:0]       tag_id_d [LAT];
    logic [IDW+RES_W-1:0] mem_q [DEPTH];
    logic [IDW+RES_W-1:0] head;

    logic [5:0]           cfg_arr [NREQ];
    logic [NREQ-1:0]      grant;
    logic                 issue;
    logic [IDW-1:0]       grant_id;
    logic [IDW-1:0]       idx;
    logic                 push;
    logic                 pop;
    logic                 empty;

    // The search begins one past the last accepted requester; no credits means no grant at all.
    always_comb begin
        grant    = '0;
        issue    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cfg_arr[i] = req_cfg[6*i +: 6];
        end
        if (!rst && credits_q != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = IDW'((int'(last_q) + k) % NREQ);
                if (!issue && req_valid[idx]) begin
                    issue       = 1'b1;
                    grant[idx]  = 1'b1;
                    grant_id    = idx;
                end
            end
        end
    end

    assign empty = (wr_q == rd_q);
    assign push  = tag_vld_q[LAT-1];
    assign pop   = !empty && resp_ready;
    assign head  = mem_q[rd_q[PW-1:0]];

    always_comb begin
        tag_vld_d[0] = issue;
        tag_id_d[0]  = grant_id;
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
        wr_d      = push ? wr_q + 1'b1 : wr_q;
        rd_d      = pop  ? rd_q + 1'b1 : rd_q;
        credits_d = credits_q - CW'(issue) + CW'(pop);
        last_d    = issue ? grant_id : last_q;
    end

    // Reset discards everything in flight; the fma keeps running but its stale outputs carry no tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= IDW'(NREQ - 1);
            credits_q <= CW'(DEPTH);
            wr_q      <= '0;
            rd_q      <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            last_q    <= last_d;
            credits_q <= credits_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            tag_vld_q <= tag_vld_d;
            for (int i = 0; i < LAT; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[PW-1:0]] <= {tag_id_q[LAT-1], res_data};
        end
    end

    assign req_ready   = grant;
    assign fma_sel     = grant;
    assign issue_valid = issue;
    assign fma_cfg     = issue ? cfg_arr[grant_id] : 6'b0;
    assign resp_valid  = !empty;
    assign resp_id     = empty ? '0 : head[IDW+RES_W-1:RES_W];
    assign resp_data   = empty ? '0 : head[RES_W-1:0];
    assign credits     = credits_q;
    assign idle        = (tag_vld_q == '0) && empty;

`ifdef FMA_SCHED_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issue_d = perf_issue_q + 32'(issue);
        perf_stall_d = perf_stall_q + 32'((|req_valid) && (credits_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue = perf_issue_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fma_sched.sv
// Self-checking bench for fma_sched: queue-based reference model of grants, credits and in-order results.
module tb_fma_sched;
    localparam int NREQ  = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int RES_W = 300;
    localparam int IDW   = 2;
    localparam int CW    = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [6*NREQ-1:0]  req_cfg = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    fma_sel;
    logic [5:0]         fma_cfg;
    logic               issue_valid;
    logic [RES_W-1:0]   res_data;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic [IDW-1:0]     resp_id;
    logic [RES_W-1:0]   resp_data;
    logic [CW-1:0]      credits;
    logic               idle;
`ifdef FMA_SCHED_PERF_EN
    logic [31:0]        perf_issue;
    logic [31:0]        perf_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fma_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .RES_W(RES_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_cfg(req_cfg),
        .req_ready(req_ready), .fma_sel(fma_sel), .fma_cfg(fma_cfg),
        .issue_valid(issue_valid), .res_data(res_data), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .credits(credits), .idle(idle)
`ifdef FMA_SCHED_PERF_EN
        , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: every accepted issue is one outstanding entry until popped.
    typedef struct {
        int               id;
        logic [RES_W-1:0] data;
        int               t;
    } ent_t;

    ent_t             exp_q[$];
    int               m_last = NREQ - 1;
    int               cyc = 0;
    int               m_pissue = 0;
    int               m_pstall = 0;
    logic [RES_W-1:0] pipe [LAT];
    logic [RES_W-1:0] tok;

    assign res_data = pipe[LAT-1];

    function automatic int m_grant();
        if (rst || exp_q.size() >= DEPTH) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic m_valid();
        if (exp_q.size() == 0) return 1'b0;
        return cyc >= exp_q[0].t + LAT;
    endfunction

    always @(posedge clk or posedge rst) begin
        int   g;
        logic pv;
        for (int k = 0; k < 10; k++) tok = {tok[RES_W-33:0], 32'($urandom())};
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= tok;
        if (rst) begin
            exp_q.delete();
            m_last   = NREQ - 1;
            m_pissue = 0;
            m_pstall = 0;
        end else begin
            g  = m_grant();
            pv = m_valid() && resp_ready;
            if (req_valid != '0 && exp_q.size() >= DEPTH) m_pstall++;
            cyc++;
            if (pv) void'(exp_q.pop_front());
            if (g >= 0) begin
                exp_q.push_back('{g, tok, cyc});
                m_last = g;
                m_pissue++;
            end
        end
    end

    task automatic cycle(input logic [NREQ-1:0] v, input logic [6*NREQ-1:0] c, input logic rr);
        @(negedge clk);
        req_valid  = v;
        req_cfg    = c;
        resp_ready = rr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '1;
        req_cfg    = (6*NREQ)'($urandom());
        resp_ready = 1'b1;
        #1;
        for (int r = 0; r < 2; r++) begin
            n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
            n_tests++; if (fma_sel !== '0) begin n_fail++; $display("FAIL reset_fma_sel got %b exp 0", fma_sel); end
            n_tests++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue got %b exp 0", issue_valid); end
            n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
            n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", idle); end
            n_tests++; if (fma_cfg !== 6'b0) begin n_fail++; $display("FAIL reset_fma_cfg got %h exp 0", fma_cfg); end
            n_tests++; if (resp_id !== '0) begin n_fail++; $display("FAIL reset_resp_id got %0d exp 0", resp_id); end
            n_tests++; if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data got %h exp 0", resp_data); end
            n_tests++; if (credits !== CW'(DEPTH)) begin n_fail++; $display("FAIL reset_credits got %0d exp %0d", credits, DEPTH); end
            @(negedge clk);
            #1;
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int first_v = -1;
        int pops = 0;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            cycle('1, (6*NREQ)'($urandom()), 1'b1);
            n_tests++; if (req_ready !== (NREQ'(1) << (k % NREQ))) begin
                n_fail++; $display("FAIL rr_grant cycle %0d got %b exp %b", k, req_ready, NREQ'(1) << (k % NREQ)); end
            n_tests++; if (fma_cfg !== req_cfg[6*(k % NREQ) +: 6]) begin
                n_fail++; $display("FAIL rr_cfg cycle %0d got %h exp %h", k, fma_cfg, req_cfg[6*(k % NREQ) +: 6]); end
            n_tests++; if (resp_valid !== m_valid()) begin
                n_fail++; $display("FAIL rr_resp_valid cycle %0d got %b exp %b", k, resp_valid, m_valid()); end
            if (resp_valid && first_v < 0) first_v = k;
            if (m_valid()) begin
                n_tests++; if (resp_id !== IDW'(pops % NREQ)) begin
                    n_fail++; $display("FAIL rr_resp_id pop %0d got %0d exp %0d", pops, resp_id, pops % NREQ); end
                n_tests++; if (resp_data !== exp_q[0].data) begin
                    n_fail++; $display("FAIL rr_resp_data pop %0d got %h exp %h", pops, resp_data, exp_q[0].data); end
                pops++;
            end
        end
        n_tests++; if (first_v != LAT + 1) begin n_fail++; $display("FAIL rr_first_resp got cycle %0d exp %0d", first_v, LAT + 1); end
    endtask

    task automatic test_credit_limit();
        int issues = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(4'b0100, (6*NREQ)'($urandom()), 1'b0);
            if (issue_valid) issues++;
        end
        n_tests++; if (issues != DEPTH) begin n_fail++; $display("FAIL credit_issues got %0d exp %0d", issues, DEPTH); end
        n_tests++; if (credits !== '0) begin n_fail++; $display("FAIL credit_zero got %0d exp 0", credits); end
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL credit_ready got %b exp 0", req_ready); end
        cycle(4'b0100, (6*NREQ)'($urandom()), 1'b1);
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL credit_pop_ready got %b exp 0", req_ready); end
        cycle(4'b0100, (6*NREQ)'($urandom()), 1'b0);
        n_tests++; if (credits !== CW'(1)) begin n_fail++; $display("FAIL credit_one got %0d exp 1", credits); end
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL credit_regrant got %b exp 0100", req_ready); end
        cycle(4'b0100, (6*NREQ)'($urandom()), 1'b0);
        n_tests++; if (credits !== '0) begin n_fail++; $display("FAIL credit_again_zero got %0d exp 0", credits); end
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL credit_again_ready got %b exp 0", req_ready); end
    endtask

    task automatic test_full_swap();
        int drained = 0;
        logic done = 1'b0;
        do_reset();
        for (int k = 0; k < DEPTH + LAT + 2; k++) cycle(4'b0001, (6*NREQ)'($urandom()), 1'b0);
        n_tests++; if (credits !== '0 || resp_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_state credits %0d valid %b exp 0 1", credits, resp_valid); end
        cycle('1, (6*NREQ)'($urandom()), 1'b1);
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL full_pop_ready got %b exp 0", req_ready); end
        cycle('1, (6*NREQ)'($urandom()), 1'b1);
        n_tests++; if (credits !== CW'(1) || req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL full_swap_issue credits %0d ready %b exp 1 0010", credits, req_ready); end
        cycle('1, (6*NREQ)'($urandom()), 1'b0);
        n_tests++; if (credits !== CW'(1) || req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL full_swap_hold credits %0d ready %b exp 1 0100", credits, req_ready); end
        cycle('0, '0, 1'b0);
        n_tests++; if (credits !== '0) begin n_fail++; $display("FAIL full_after_issue got %0d exp 0", credits); end
        for (int k = 0; k < 40 && !done; k++) begin
            cycle('0, '0, 1'b1);
            if (idle) done = 1'b1;
            n_tests++; if (resp_valid !== m_valid()) begin
                n_fail++; $display("FAIL full_drain_valid got %b exp %b", resp_valid, m_valid()); end
            if (m_valid()) begin
                n_tests++; if (resp_id !== IDW'(exp_q[0].id) || resp_data !== exp_q[0].data) begin
                    n_fail++; $display("FAIL full_drain_entry got id %0d exp %0d", resp_id, exp_q[0].id); end
                drained++;
            end
        end
        n_tests++; if (!done || drained != DEPTH) begin
            n_fail++; $display("FAIL full_drain_count got %0d idle %b exp %0d idle 1", drained, done, DEPTH); end
    endtask

    task automatic test_reset_flight();
        do_reset();
        for (int k = 0; k < 3; k++) cycle(4'b0001, (6*NREQ)'($urandom()), 1'b1);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b1;
        #1;
        n_tests++; if (credits !== CW'(DEPTH) || idle !== 1'b1) begin
            n_fail++; $display("FAIL flight_async credits %0d idle %b exp %0d 1", credits, idle, DEPTH); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3 * LAT; k++) begin
            cycle('0, '0, 1'b1);
            n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flight_resp_valid cycle %0d got 1 exp 0", k); end
        end
        n_tests++; if (credits !== CW'(DEPTH) || idle !== 1'b1) begin
            n_fail++; $display("FAIL flight_end credits %0d idle %b exp %0d 1", credits, idle, DEPTH); end
    endtask

    task automatic test_alternate();
        logic [5:0] c1, c3;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            c1 = 6'($urandom());
            c3 = c1 ^ 6'h2a;
            cycle(4'b1010, {c3, 6'h00, c1, 6'h00}, 1'b1);
            n_tests++; if (req_ready !== ((k % 2 == 0) ? 4'b0010 : 4'b1000) || fma_sel !== req_ready) begin
                n_fail++; $display("FAIL alt_grant cycle %0d got %b sel %b", k, req_ready, fma_sel); end
            n_tests++; if (fma_cfg !== ((k % 2 == 0) ? c1 : c3) || issue_valid !== 1'b1) begin
                n_fail++; $display("FAIL alt_cfg cycle %0d got %h issue %b exp %h 1", k, fma_cfg, issue_valid, (k % 2 == 0) ? c1 : c3); end
        end
    endtask

    task automatic test_random();
        int g;
        logic [NREQ-1:0] eg;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            cycle(NREQ'($urandom()), (6*NREQ)'($urandom()),
                  (k < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            g  = m_grant();
            eg = (g >= 0) ? (NREQ'(1) << g) : '0;
            n_tests++; if (req_ready !== eg || issue_valid !== (g >= 0)) begin
                n_fail++; $display("FAIL rand_grant cycle %0d got %b exp %b", k, req_ready, eg); end
            n_tests++; if (fma_cfg !== ((g >= 0) ? req_cfg[6*g +: 6] : 6'b0)) begin
                n_fail++; $display("FAIL rand_cfg cycle %0d got %h", k, fma_cfg); end
            n_tests++; if (credits !== CW'(DEPTH - exp_q.size()) || idle !== (exp_q.size() == 0)) begin
                n_fail++; $display("FAIL rand_credits cycle %0d got %0d idle %b exp %0d", k, credits, idle, DEPTH - exp_q.size()); end
            n_tests++; if (resp_valid !== m_valid()) begin
                n_fail++; $display("FAIL rand_resp_valid cycle %0d got %b exp %b", k, resp_valid, m_valid()); end
            if (m_valid()) begin
                n_tests++; if (resp_id !== IDW'(exp_q[0].id) || resp_data !== exp_q[0].data) begin
                    n_fail++; $display("FAIL rand_head cycle %0d got id %0d exp %0d", k, resp_id, exp_q[0].id); end
            end
        end
    endtask

`ifdef FMA_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int k = 0; k < DEPTH + 5; k++) cycle(4'b0001, '0, 1'b0);
        for (int k = 0; k < LAT; k++) cycle('0, '0, 1'b0);
        for (int k = 0; k < 2; k++) cycle('0, '0, 1'b1);
        for (int k = 0; k < 2; k++) cycle(4'b0001, '0, 1'b0);
        cycle('0, '0, 1'b0);
        n_tests++; if (perf_issue !== 32'd10 || perf_issue !== 32'(m_pissue)) begin
            n_fail++; $display("FAIL perf_issue got %0d exp 10", perf_issue); end
        n_tests++; if (perf_stall !== 32'd5 || perf_stall !== 32'(m_pstall)) begin
            n_fail++; $display("FAIL perf_stall got %0d exp 5", perf_stall); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests %0d", n_tests);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_full_swap();
        test_reset_flight();
        test_alternate();
        test_random();
`ifdef FMA_SCHED_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
